// File: rtl/aes_key_expand_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_key_expand_if : request/status/read-port and S-box bundle        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface aes_key_expand_if #(
  parameter int MAX_NK   = 8,
  parameter int RK_IDX_W = 4
);
  logic                    start;
  logic [1:0]              key_len;
  logic [32*MAX_NK-1:0]    key;
  logic [31:0]             sboxw;
  logic [31:0]             new_sboxw;
  logic                    busy;
  logic                    ready;
  logic [3:0]              nr;
  logic [RK_IDX_W-1:0]     rk_idx;
  logic [127:0]            rk_data;

  modport master (
    output start, key_len, key, new_sboxw, rk_idx,
    input  sboxw, busy, ready, nr, rk_data
  );

  modport slave (
    input  start, key_len, key, new_sboxw, rk_idx,
    output sboxw, busy, ready, nr, rk_data
  );
endinterface
`default_nettype wire

// File: rtl/aes_key_expand.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_key_expand : AES-128/192/256 key schedule, one word per clock    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module aes_key_expand #(
  parameter int MAX_NK   = 8,
  parameter int RK_IDX_W = 4
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  aes_key_expand_if.slave    bus
);

  localparam int DEPTH = 4 * (MAX_NK + 7);
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     nk_q, nk_d;
  logic [3:0]     nr_q, nr_d;
  logic [AW-1:0]  i_q, i_d;
  logic [3:0]     kcnt_q, kcnt_d;
  logic [7:0]     rcon_q, rcon_d;
  logic [127:0]   rk_data_q, rk_data_d;
  logic [31:0]    w_mem_q [DEPTH];

  logic           load;
  logic           wr_en;
  logic [3:0]     nk_sel, nr_sel;
  logic [31:0]    prev_w, old_w, temp, new_word, sboxw;
  logic [AW-1:0]  rd_base;
  logic           last_word;

  always_comb begin
    nk_sel = 4'd4;
    nr_sel = 4'd10;
    case (bus.key_len)
      2'b01:   begin nk_sel = 4'd6; nr_sel = 4'd12; end
      2'b10:   begin nk_sel = 4'd8; nr_sel = 4'd14; end
      default: begin nk_sel = 4'd4; nr_sel = 4'd10; end
    endcase
  end

  assign prev_w    = w_mem_q[i_q - AW'(1)];
  assign old_w     = w_mem_q[i_q - AW'(nk_q)];
  // Last index of the schedule is 4*Nr+3.
  assign last_word = (i_q == AW'({nr_q, 2'b11}));

  always_comb begin
    state_d  = state_q;
    nk_d     = nk_q;
    nr_d     = nr_q;
    i_d      = i_q;
    kcnt_d   = kcnt_q;
    rcon_d   = rcon_q;
    load     = 1'b0;
    wr_en    = 1'b0;
    sboxw    = 32'h0;
    temp     = prev_w;
    new_word = old_w ^ prev_w;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          load    = 1'b1;
          nk_d    = nk_sel;
          nr_d    = nr_sel;
          i_d     = AW'(nk_sel);
          kcnt_d  = 4'd0;
          rcon_d  = 8'h01;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        wr_en = 1'b1;
        sboxw = prev_w;
        // kcnt_q tracks i mod Nk so no divider is needed.
        if (kcnt_q == 4'd0) begin
          sboxw  = {prev_w[23:0], prev_w[31:24]};
          temp   = bus.new_sboxw ^ {rcon_q, 24'h0};
          rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        end else if ((nk_q == 4'd8) && (kcnt_q == 4'd4)) begin
          temp = bus.new_sboxw;
        end
        new_word = old_w ^ temp;
        i_d      = i_q + AW'(1);
        kcnt_d   = (kcnt_q == nk_q - 4'd1) ? 4'd0 : kcnt_q + 4'd1;
        if (last_word) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_base = AW'({bus.rk_idx, 2'b00});

  always_comb begin
    rk_data_d = 128'h0;
    if (bus.rk_idx <= RK_IDX_W'(nr_q)) begin
      rk_data_d = {w_mem_q[rd_base], w_mem_q[rd_base + AW'(1)],
                   w_mem_q[rd_base + AW'(2)], w_mem_q[rd_base + AW'(3)]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      nk_q      <= 4'd0;
      nr_q      <= 4'd0;
      i_q       <= '0;
      kcnt_q    <= 4'd0;
      rcon_q    <= 8'h00;
      rk_data_q <= 128'h0;
    end else begin
      state_q   <= state_d;
      nk_q      <= nk_d;
      nr_q      <= nr_d;
      i_q       <= i_d;
      kcnt_q    <= kcnt_d;
      rcon_q    <= rcon_d;
      rk_data_q <= rk_data_d;
    end
  end

  // Word storage is deliberately not reset; a fresh start always rewrites it.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < MAX_NK; k++) begin
        if (4'(k) < nk_sel) begin
          w_mem_q[AW'(k)] <= bus.key[32*(MAX_NK-k)-1 -: 32];
        end
      end
    end else if (wr_en) begin
      w_mem_q[i_q] <= new_word;
    end
  end

  assign bus.sboxw   = sboxw;
  assign bus.busy    = (state_q == EXPAND);
  assign bus.ready   = (state_q == DONE);
  assign bus.nr      = nr_q;
  assign bus.rk_data = rk_data_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expand.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_aes_key_expand : scoreboard bench with FIPS-197 key vectors       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_aes_key_expand;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  aes_key_expand_if #(.MAX_NK(8), .RK_IDX_W(4)) bus ();

  aes_key_expand #(.MAX_NK(8), .RK_IDX_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    string        name;
    logic [127:0] exp;
  } exp_t;
  exp_t sb_q[$];

  logic rd_req = 1'b0;
  logic rd_vld = 1'b0;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int n = 0; n < 8; n++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  // Independent S-box: multiplicative inverse (x^254) then affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p, r, s;
    p = x; r = 8'h01;
    for (int n = 1; n < 8; n++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    return s;
  endfunction

  always_comb begin
    bus.new_sboxw = {sbox(bus.sboxw[31:24]), sbox(bus.sboxw[23:16]),
                     sbox(bus.sboxw[15:8]),  sbox(bus.sboxw[7:0])};
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) rd_vld <= rd_req;

  always @(negedge clk) begin
    if (rd_vld) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard underflow: got %h expected none", bus.rk_data);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check(e.name, bus.rk_data, e.exp);
      end
    end
  end

  // Called #1 after a rising edge; rk_data is checked by the monitor a cycle later.
  task automatic rd(input logic [3:0] idx, input logic [127:0] exp, input string name);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    bus.rk_idx = idx;
    rd_req     = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic kick(input logic [1:0] len, input logic [255:0] k);
    bus.key_len = len;
    bus.key     = k;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.key   = {256{1'b1}};
    check("ready_drop", 128'(bus.ready), 128'd0);
    check("busy_set", 128'(bus.busy), 128'd1);
  endtask

  task automatic wait_ready(input int exp_cyc, input int pulse_at, input string name);
    int cnt;
    cnt = 0;
    while (!bus.ready && cnt < 200) begin
      @(posedge clk);
      cnt++;
      #1;
      bus.start = (cnt == pulse_at);
    end
    bus.start = 1'b0;
    check({name, "_latency"}, 128'(cnt), 128'(exp_cyc));
    check({name, "_busy_done"}, 128'(bus.busy), 128'd0);
    check({name, "_sboxw_idle"}, 128'(bus.sboxw), 128'd0);
  endtask

  initial begin
    reset_n     = 1'b0;
    bus.start   = 1'b0;
    bus.key_len = 2'b00;
    bus.key     = '0;
    bus.rk_idx  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 128'(bus.busy), 128'd0);
    check("rst_ready", 128'(bus.ready), 128'd0);
    check("rst_nr", 128'(bus.nr), 128'd0);
    check("rst_rk_data", bus.rk_data, 128'd0);
    check("rst_sboxw", 128'(bus.sboxw), 128'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // AES-128 baseline
    kick(2'b00, K128);
    wait_ready(40, -1, "aes128");
    check("aes128_nr", 128'(bus.nr), 128'd10);
    rd(4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, "aes128_rk0");
    rd(4'd1,  128'ha0fafe1788542cb123a339392a6c7605, "aes128_rk1");
    rd(4'd2,  128'hf2c295f27a96b9435935807a7359f67f, "aes128_rk2");
    rd(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "aes128_rk10");
    rd(4'd11, 128'h0, "aes128_rk11_oob");
    rd(4'd15, 128'h0, "aes128_rk15_oob");

    // start re-pulsed mid-expansion must be ignored
    kick(2'b00, K128);
    wait_ready(40, 10, "repulse");
    rd(4'd1,  128'ha0fafe1788542cb123a339392a6c7605, "repulse_rk1");
    rd(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "repulse_rk10");

    // AES-256 straight from DONE
    kick(2'b10, K256);
    wait_ready(52, -1, "aes256");
    check("aes256_nr", 128'(bus.nr), 128'd14);
    rd(4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde, "aes256_rk2");
    rd(4'd3,  128'ha8b09c1a93d194cdbe49846eb75d5b9a, "aes256_rk3");
    rd(4'd14, 128'hfe4890d1e6188d0b046df344706c631e, "aes256_rk14");
    rd(4'd15, 128'h0, "aes256_rk15_oob");

    // AES-192
    kick(2'b01, K192);
    wait_ready(46, -1, "aes192");
    check("aes192_nr", 128'(bus.nr), 128'd12);
    rd(4'd1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5, "aes192_rk1");
    rd(4'd12, 128'he98ba06f448c773c8ecc720401002202, "aes192_rk12");
    rd(4'd13, 128'h0, "aes192_rk13_oob");

    // Asynchronous reset in the middle of an AES-192 expansion
    kick(2'b01, K192);
    repeat (19) @(posedge clk);
    #2;
    check("abort_busy_before", 128'(bus.busy), 128'd1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", 128'(bus.busy), 128'd0);
    check("abort_ready", 128'(bus.ready), 128'd0);
    check("abort_rk_data", bus.rk_data, 128'd0);
    check("abort_nr", 128'(bus.nr), 128'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    kick(2'b01, K192);
    wait_ready(46, -1, "restart192");
    rd(4'd12, 128'he98ba06f448c773c8ecc720401002202, "restart192_rk12");

    // Reserved key_len behaves as AES-128
    kick(2'b11, K128);
    wait_ready(40, -1, "len11");
    check("len11_nr", 128'(bus.nr), 128'd10);
    rd(4'd1,  128'ha0fafe1788542cb123a339392a6c7605, "len11_rk1");
    rd(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "len11_rk10");
    rd(4'd11, 128'h0, "len11_rk11_oob");

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 128'(sb_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
Parametrised AES key-schedule engine supporting AES-128/192/256, selected per operation by `key_len`.
- Expands a left-aligned key into Nt = 4·(Nr+1) 32-bit words, one word per clock.
- SubWord uses a shared external combinational 4-byte S-box: `sboxw` out, `new_sboxw` back in the same cycle.
- Round keys are served through an indexed, registered read port to the cipher datapath.
- Successor to the fixed AES-128 key map: adds a start/ready handshake, 192/256-bit keys, on-the-fly Rcon and re-keying without reset.

Parameters:
- MAX_NK, 8, maximum key words supported; fixes key port width (32·MAX_NK) and storage depth 4·(MAX_NK+7)=60 words.
- RK_IDX_W, 4, width of round-key index (covers rounds 0..14).

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  begin expansion; sampled only in IDLE or DONE.
- key_len  input  2  00=AES-128 (Nk4,Nr10), 01=AES-192 (Nk6,Nr12), 10=AES-256 (Nk8,Nr14), 11=reserved (treated as 00); sampled with start.
- key  input  32·MAX_NK  key, word 0 = key[255:224]; AES-128 uses key[255:128], AES-192 uses key[255:64].
- sboxw  output  32  word to external S-box.
- new_sboxw  input  32  S-box result of `sboxw`, combinational, same cycle.
- busy  output  1  expansion in progress.
- ready  output  1  schedule complete and valid.
- nr  output  4  round count of latched key_len (10/12/14).
- rk_idx  input  RK_IDX_W  round-key index to read.
- rk_data  output  128  {w[4r], w[4r+1], w[4r+2], w[4r+3]} for r=rk_idx, registered.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; busy=0, ready=0, nr=0, rk_data=0, sboxw=0.
  - Counter and Rcon register cleared. Word storage not cleared.
- States IDLE, EXPAND, DONE.
- start in IDLE or DONE:
  - Latch Nk/Nr from key_len; write w[0..Nk-1] from key.
  - i=Nk, rcon=8'h01, busy=1, ready=0, next state EXPAND.
- start while EXPAND: ignored. Current expansion continues unaltered.
- EXPAND generates one word per cycle, w[i] = w[i-Nk] ^ temp:
  - i mod Nk == 0: temp = new_sboxw ^ {rcon,24'h0}, with sboxw = RotWord(w[i-1]) = {w[i-1][23:0], w[i-1][31:24]}; then rcon = xtime(rcon) (shift left 1; if msb was 1, xor 8'h1b).
  - Nk==8 and i mod 8 == 4: temp = new_sboxw, with sboxw = w[i-1] (no rotate, no Rcon).
  - Otherwise: temp = w[i-1], and sboxw = w[i-1] (value ignored).
  - i increments each cycle. The word at i = Nt-1 is the last; Nt = 44/52/60.
- Leaving EXPAND:
  - After the edge writing w[Nt-1], state=DONE, busy=0, ready=1.
  - ready rises 40/46/52 cycles after the start-sampling edge (Nt-Nk words).
- DONE:
  - ready held until the next accepted start, which drops it the following cycle.
  - sboxw=0 in IDLE/DONE.
- Read port:
  - rk_data updates on the clock edge after rk_idx presented (1-cycle latency).
  - rk_idx > nr → rk_data = 0.
  - Reads during EXPAND return current storage contents; data is valid only when ready=1.
- Rcon sequence: 01,02,04,08,10,20,40,80,1b,36. AES-256 uses 7 values, AES-192 uses 8.
- Reset mid-expansion aborts immediately to IDLE with ready=0; a subsequent start re-expands fully.

Test Plan:
- AES-128 key 2b7e151628aed2a6abf7158809cf4f3c, start → ready after 40 cycles; rk_idx=1 → a0fafe1788542cb123a339392a6c7605; rk_idx=10 → d014f9a8c9ee2589e13f0cc8b6630ca6; rk_idx=11 → 0.
- AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → ready after 46 cycles, nr=12; rk_idx=12 → e98ba06f448c773c8ecc720401002202.
- AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → ready after 52 cycles, nr=14; rk_idx=14 → fe4890d1e6188d0b046df344706c631e (exercises the i mod 8==4 SubWord path).
- start re-pulsed at cycle 10 of AES-128 expansion → ignored; results identical to scenario 1. Then start AES-256 from DONE → ready drops next cycle, new schedule correct.
- reset_n low at cycle 20 of AES-192 expansion → busy=0, ready=0, rk_data=0 asynchronously; restart yields the correct schedule.
- key_len=11 with the AES-128 key → behaves as AES-128 (nr=10, same keys as scenario 1).
